// File: rtl/sprite_draw_engine_pkg.sv
// rtl/sprite_draw_engine_pkg.sv - shared constants, colour type and state enums for the sprite draw engine
package sprite_pkg;

  localparam int SPRITE_W_DEF = 10;
  localparam int SPRITE_H_DEF = 16;
  localparam int SCREEN_W_DEF = 320;
  localparam int SCREEN_H_DEF = 240;

  typedef logic [8:0] colour_t;
  localparam colour_t TRANSPARENT_DEF = 9'h1FF;

  localparam int BG_AW     = 17;
  localparam int SP_AW_DEF = $clog2(SPRITE_W_DEF * SPRITE_H_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCAN,
    ST_FLUSH,
    ST_DONE,
    ST_RELEASE
  } state_e;

  typedef enum logic {
    MODE_BG,
    MODE_CHAR
  } mode_e;

endpackage

// File: rtl/sprite_draw_engine_if.sv
// rtl/sprite_draw_engine_if.sv - request/done handshake, ROM ports and VGA write port of the draw engine
interface sprite_draw_engine_if
  import sprite_pkg::*;
#(
  parameter int SP_AW = SP_AW_DEF
);
  logic             drawBG;
  logic             drawChar;
  logic [8:0]       xCoordinate;
  logic [7:0]       yCoordinate;
  logic             doneBG;
  logic             doneChar;
  logic [BG_AW-1:0] bgAddr;
  colour_t          bgData;
  logic [SP_AW-1:0] spAddr;
  colour_t          spData;
  logic             plot;
  logic [8:0]       vgaX;
  logic [7:0]       vgaY;
  colour_t          colour;

  modport master (
    output drawBG, drawChar, xCoordinate, yCoordinate, bgData, spData,
    input  doneBG, doneChar, bgAddr, spAddr, plot, vgaX, vgaY, colour
  );

  modport slave (
    input  drawBG, drawChar, xCoordinate, yCoordinate, bgData, spData,
    output doneBG, doneChar, bgAddr, spAddr, plot, vgaX, vgaY, colour
  );
endinterface

// File: rtl/sprite_draw_engine_addr_gen.sv
// rtl/sprite_draw_engine_addr_gen.sv - col/row scan counters, screen position, clip flag and ROM addresses
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int SPRITE_W = SPRITE_W_DEF,
  parameter int SPRITE_H = SPRITE_H_DEF,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clear,
  input  logic                                  advance,
  input  logic signed [9:0]                     ox,
  input  logic signed [9:0]                     oy,
  output logic                                  last,
  output logic                                  in_screen,
  output logic [8:0]                            px,
  output logic [7:0]                            py,
  output logic [BG_AW-1:0]                      bg_addr,
  output logic [$clog2(SPRITE_W*SPRITE_H)-1:0]  sp_addr
);
  localparam int CW    = $clog2(SPRITE_W);
  localparam int RW    = $clog2(SPRITE_H);
  localparam int SP_AW = $clog2(SPRITE_W * SPRITE_H);
  localparam logic signed [10:0] SCR_W = 11'(SCREEN_W);
  localparam logic signed [10:0] SCR_H = 11'(SCREEN_H);

  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic signed [10:0] sx, sy;
  logic               col_end, row_end;

  assign col_end = (col_q == CW'(SPRITE_W - 1));
  assign row_end = (row_q == RW'(SPRITE_H - 1));
  assign last    = col_end && row_end;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (advance) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // One extra bit over the origin so the right/bottom box edge cannot wrap negative.
  always_comb begin
    sx        = {ox[9], ox} + 11'(col_q);
    sy        = {oy[9], oy} + 11'(row_q);
    in_screen = !sx[10] && !sy[10] && (sx < SCR_W) && (sy < SCR_H);
    px        = sx[8:0];
    py        = sy[7:0];
    bg_addr   = '0;
    sp_addr   = '0;
    if (advance && in_screen) begin
      bg_addr = (BG_AW'(py) << 8) + (BG_AW'(py) << 6) + BG_AW'(px);
      sp_addr = SP_AW'(row_q) * SP_AW'(SPRITE_W) + SP_AW'(col_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end
endmodule

// File: rtl/sprite_draw_engine.sv
// rtl/sprite_draw_engine.sv - scans the sprite box and emits one VGA write per visible pixel, then a done pulse
// SPRITE_TRANSPARENCY_EN: when defined, CHAR-mode pixels equal to TRANSPARENT are not plotted.
module sprite_draw_engine
  import sprite_pkg::*;
#(
  parameter int      SPRITE_W    = SPRITE_W_DEF,
  parameter int      SPRITE_H    = SPRITE_H_DEF,
  parameter int      SCREEN_W    = SCREEN_W_DEF,
  parameter int      SCREEN_H    = SCREEN_H_DEF,
  parameter colour_t TRANSPARENT = TRANSPARENT_DEF
) (
  input  logic                clock,
  input  logic                reset,
  sprite_draw_engine_if.slave bus
);
`ifdef SPRITE_TRANSPARENCY_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif
  localparam int SP_AW = $clog2(SPRITE_W * SPRITE_H);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic signed [9:0]  ox_q, ox_d, oy_q, oy_d;
  logic               done_bg_q, done_bg_d, done_char_q, done_char_d;
  logic               pipe_valid_q, pipe_valid_d;
  logic [8:0]         pipe_x_q, pipe_x_d;
  logic [7:0]         pipe_y_q, pipe_y_d;
  logic               plot_q, plot_d;
  logic [8:0]         vga_x_q, vga_x_d;
  logic [7:0]         vga_y_q, vga_y_d;
  colour_t            colour_q, colour_d;

  logic               scanning, last_px, in_screen, key_hit;
  logic [8:0]         px;
  logic [7:0]         py;
  logic [BG_AW-1:0]   bg_addr;
  logic [SP_AW-1:0]   sp_addr;

  assign scanning = (state_q == ST_SCAN);

  sprite_addr_gen #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_addr_gen (
    .clk       (clock),
    .rst       (reset),
    .clear     (state_q == ST_LOAD),
    .advance   (scanning),
    .ox        (ox_q),
    .oy        (oy_q),
    .last      (last_px),
    .in_screen (in_screen),
    .px        (px),
    .py        (py),
    .bg_addr   (bg_addr),
    .sp_addr   (sp_addr)
  );

  // Mode and origin are captured on acceptance so coordinates only matter while idle.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    done_bg_d   = 1'b0;
    done_char_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.drawBG || bus.drawChar) begin
          state_d = ST_LOAD;
          mode_d  = bus.drawBG ? MODE_BG : MODE_CHAR;
          ox_d    = 10'({1'b0, bus.xCoordinate}) - 10'(SPRITE_W / 2);
          oy_d    = 10'({2'b00, bus.yCoordinate}) - 10'(SPRITE_H - 1);
        end
      end
      ST_LOAD:  state_d = ST_SCAN;
      ST_SCAN:  if (last_px) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE: begin
        state_d     = ST_RELEASE;
        done_bg_d   = (mode_q == MODE_BG);
        done_char_d = (mode_q == MODE_CHAR);
      end
      ST_RELEASE: if (!bus.drawBG && !bus.drawChar) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pipe_valid_d = scanning && in_screen;
    pipe_x_d     = px;
    pipe_y_d     = py;
    key_hit      = (bus.spData == TRANSPARENT);
    plot_d       = pipe_valid_q && !(TRANSP_EN && (mode_q == MODE_CHAR) && key_hit);
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    colour_d     = colour_q;
    if (plot_d) begin
      vga_x_d  = pipe_x_q;
      vga_y_d  = pipe_y_q;
      colour_d = (mode_q == MODE_CHAR) ? bus.spData : bus.bgData;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_BG;
      ox_q         <= '0;
      oy_q         <= '0;
      done_bg_q    <= 1'b0;
      done_char_q  <= 1'b0;
      pipe_valid_q <= 1'b0;
      pipe_x_q     <= '0;
      pipe_y_q     <= '0;
      plot_q       <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      colour_q     <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      done_bg_q    <= done_bg_d;
      done_char_q  <= done_char_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_x_q     <= pipe_x_d;
      pipe_y_q     <= pipe_y_d;
      plot_q       <= plot_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      colour_q     <= colour_d;
    end
  end

  assign bus.doneBG   = done_bg_q;
  assign bus.doneChar = done_char_q;
  assign bus.bgAddr   = bg_addr;
  assign bus.spAddr   = sp_addr;
  assign bus.plot     = plot_q;
  assign bus.vgaX     = vga_x_q;
  assign bus.vgaY     = vga_y_q;
  assign bus.colour   = colour_q;
endmodule

// File: tb/tb_sprite_draw_engine.sv
// tb/tb_sprite_draw_engine.sv - randomized self-checking bench for sprite_draw_engine against a box-scan model
module tb_sprite_draw_engine;
  import sprite_pkg::*;

`ifdef SPRITE_TRANSPARENCY_EN
  localparam bit TB_TRANSP = 1'b1;
`else
  localparam bit TB_TRANSP = 1'b0;
`endif

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [8:0] c;
  } pix_t;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  sprite_draw_engine_if bus ();

  sprite_draw_engine dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  logic [8:0] bg_rom [0:76799];
  logic [8:0] sp_rom [0:159];

  always @(posedge clock) begin
    bus.bgData <= (int'(bus.bgAddr) < 76800) ? bg_rom[bus.bgAddr] : 9'h000;
    bus.spData <= (int'(bus.spAddr) < 160)   ? sp_rom[bus.spAddr] : 9'h000;
  end

  pix_t obs_q[$];
  pix_t exp_q[$];
  int   req_cyc, done_cyc, first_plot, last_plot, n_bg, n_ch;

  // Reference: walk the 10x16 box around the anchor, keep on-screen (and, if keyed, opaque) pixels.
  task automatic build_expected(input bit ch, input int x, input int y);
    int sx, sy, idx;
    exp_q.delete();
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 10; c++) begin
        sx  = x - 5 + c;
        sy  = y - 15 + r;
        idx = r * 10 + c;
        if (sx >= 0 && sx < 320 && sy >= 0 && sy < 240) begin
          if (!(ch && TB_TRANSP && sp_rom[idx] == 9'h1FF))
            exp_q.push_back('{x: 9'(sx), y: 8'(sy), c: ch ? sp_rom[idx] : bg_rom[sy * 320 + sx]});
        end
      end
    end
  endtask

  function automatic int count_diffs();
    int n, m;
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    n = (obs_q.size() > exp_q.size()) ? obs_q.size() - m : exp_q.size() - m;
    for (int i = 0; i < m; i++) if (obs_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  task automatic run_draw(input bit bg, input bit ch, input int x, input int y, input bit hold_char);
    obs_q.delete();
    n_bg = 0; n_ch = 0; done_cyc = -1; first_plot = -1; last_plot = -1;
    @(negedge clock);
    bus.drawBG = bg; bus.drawChar = ch;
    bus.xCoordinate = 9'(x); bus.yCoordinate = 8'(y);
    req_cyc = cyc + 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (bus.plot) begin
        obs_q.push_back('{x: bus.vgaX, y: bus.vgaY, c: bus.colour});
        if (first_plot < 0) first_plot = cyc;
        last_plot = cyc;
      end
      if (bus.doneBG) n_bg++;
      if (bus.doneChar) n_ch++;
      if ((bus.doneBG || bus.doneChar) && done_cyc < 0) done_cyc = cyc;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    bus.drawBG = 1'b0;
    if (!hold_char) bus.drawChar = 1'b0;
    bus.xCoordinate = 9'($urandom);
    bus.yCoordinate = 8'($urandom);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.drawBG = 1'b1;
    repeat (3) begin
      @(negedge clock);
      checks++;
      if ({bus.plot, bus.doneBG, bus.doneChar} !== 3'b000) begin
        failures++;
        $display("FAIL reset_ctrl plot/doneBG/doneChar got=%b exp=000", {bus.plot, bus.doneBG, bus.doneChar});
      end
      checks++;
      if ({bus.vgaX, bus.vgaY, bus.colour, bus.bgAddr, bus.spAddr} !== '0) begin
        failures++;
        $display("FAIL reset_data x=%0d y=%0d c=%0h bgA=%0d spA=%0d exp all 0",
                 bus.vgaX, bus.vgaY, bus.colour, bus.bgAddr, bus.spAddr);
      end
    end
    reset = 1'b0;
    bus.drawBG = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (bus.plot !== 1'b0) begin
      failures++;
      $display("FAIL idle_quiet plot got=%b exp=0", bus.plot);
    end
  endtask

  task automatic check_draw(input string nm, input int exp_cnt, input bit exp_bg);
    checks++;
    if (obs_q.size() !== exp_cnt) begin
      failures++;
      $display("FAIL %s_count got=%0d exp=%0d", nm, obs_q.size(), exp_cnt);
    end
    checks++;
    if (count_diffs() !== 0) begin
      failures++;
      $display("FAIL %s_pixels mismatched=%0d exp=0", nm, count_diffs());
    end
    checks++;
    if (done_cyc !== req_cyc + 163) begin
      failures++;
      $display("FAIL %s_done_time got=%0d exp=%0d", nm, done_cyc - req_cyc, 163);
    end
    checks++;
    if (n_bg !== int'(exp_bg) || n_ch !== int'(!exp_bg)) begin
      failures++;
      $display("FAIL %s_done_kind bg=%0d ch=%0d exp bg=%0d ch=%0d", nm, n_bg, n_ch, exp_bg, !exp_bg);
    end
  endtask

  task automatic test_bg_draw();
    int x, y;
    for (int t = 0; t < 4; t++) begin
      x = (t == 0) ? 95 : $urandom_range(5, 315);
      y = (t == 0) ? 221 : $urandom_range(15, 239);
      build_expected(1'b0, x, y);
      run_draw(1'b1, 1'b0, x, y, 1'b0);
      check_draw("bg", 160, 1'b1);
      checks++;
      if (first_plot !== req_cyc + 3 || last_plot !== req_cyc + 162) begin
        failures++;
        $display("FAIL bg_plot_window got=%0d..%0d exp=3..162", first_plot - req_cyc, last_plot - req_cyc);
      end
    end
  endtask

  task automatic test_char_draw();
    int idx, placed, x, y;
    for (int i = 0; i < 160; i++) sp_rom[i] = 9'($urandom_range(0, 510));
    placed = 0;
    while (placed < 20) begin
      idx = $urandom_range(0, 159);
      if (sp_rom[idx] != 9'h1FF) begin
        sp_rom[idx] = 9'h1FF;
        placed++;
      end
    end
    for (int t = 0; t < 2; t++) begin
      x = (t == 0) ? 95 : $urandom_range(5, 315);
      y = (t == 0) ? 221 : $urandom_range(15, 239);
      build_expected(1'b1, x, y);
      run_draw(1'b0, 1'b1, x, y, 1'b0);
      check_draw("char", TB_TRANSP ? 140 : 160, 1'b0);
    end
  endtask

  task automatic test_clip();
    int xs[5] = '{2, 95, 317, 7, 0};
    int ys[5] = '{221, 250, 5, 255, 0};
    int counts[2] = '{112, 50};
    bit ch;
    for (int t = 0; t < 5; t++) begin
      if (t >= 2) begin
        xs[t] = $urandom_range(0, 511);
        ys[t] = $urandom_range(0, 255);
      end
      ch = (t >= 2) ? 1'($urandom) : 1'b0;
      build_expected(ch, xs[t], ys[t]);
      run_draw(!ch, ch, xs[t], ys[t], 1'b0);
      check_draw("clip", (t < 2) ? counts[t] : exp_q.size(), !ch);
    end
  endtask

  task automatic test_priority();
    int extra_plot = 0, extra_done = 0;
    build_expected(1'b0, 160, 120);
    run_draw(1'b1, 1'b1, 160, 120, 1'b1);
    check_draw("prio_bg", 160, 1'b1);
    repeat (40) begin
      @(negedge clock);
      if (bus.plot) extra_plot++;
      if (bus.doneBG || bus.doneChar) extra_done++;
    end
    checks++;
    if (extra_plot !== 0 || extra_done !== 0) begin
      failures++;
      $display("FAIL prio_held plots=%0d dones=%0d exp 0/0", extra_plot, extra_done);
    end
    bus.drawChar = 1'b0;
    repeat (2) @(negedge clock);
    build_expected(1'b1, 160, 120);
    run_draw(1'b0, 1'b1, 160, 120, 1'b0);
    check_draw("prio_char", exp_q.size(), 1'b0);
  endtask

  task automatic test_reset_mid();
    int n = 0, extra_plot = 0, extra_done = 0;
    @(negedge clock);
    bus.drawBG = 1'b1; bus.xCoordinate = 9'd95; bus.yCoordinate = 8'd221;
    for (int i = 0; i < 300 && n < 50; i++) begin
      @(negedge clock);
      if (bus.plot) n++;
    end
    checks++;
    if (n !== 50) begin
      failures++;
      $display("FAIL mid_reach_50 got=%0d exp=50", n);
    end
    reset = 1'b1;
    bus.drawBG = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.plot !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_plot got=%b exp=0", bus.plot);
    end
    reset = 1'b0;
    repeat (200) begin
      @(negedge clock);
      if (bus.plot) extra_plot++;
      if (bus.doneBG || bus.doneChar) extra_done++;
    end
    checks++;
    if (extra_plot !== 0 || extra_done !== 0) begin
      failures++;
      $display("FAIL mid_aborted plots=%0d dones=%0d exp 0/0", extra_plot, extra_done);
    end
    build_expected(1'b0, 95, 221);
    run_draw(1'b1, 1'b0, 95, 221, 1'b0);
    check_draw("mid_fresh", 160, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 76800; i++) bg_rom[i] = 9'($urandom);
    for (int i = 0; i < 160; i++) sp_rom[i] = 9'($urandom_range(0, 510));
    reset = 1'b1;
    bus.drawBG = 1'b0; bus.drawChar = 1'b0;
    bus.xCoordinate = '0; bus.yCoordinate = '0;
    test_reset();
    test_bg_draw();
    test_char_draw();
    test_clip();
    test_priority();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
endmodule
